// File: rtl/fetch_queue_pkg.sv
// Shared widths and helper types for the fetch queue slice.
// WORD_DEF/ADDR_DEF are the project-wide instruction and PC widths.
package fetch_queue_pkg;

    localparam int WORD_DEF = 32;
    localparam int ADDR_DEF = 32;

    // Encoded as {push, pop} so the control vector casts straight to an op.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage for the fetch queue: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the top gates the read data with its valid flag.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_DEF + ADDR_DEF,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTRW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTRW-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: strict FIFO with stall and branch flush.
// Pointers, occupancy count and flush handling live here; storage is in fetch_queue_mem.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int WORD  = WORD_DEF,
    parameter int ADDR  = ADDR_DEF,
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v_i,
    output logic            in_rdy_o,
    input  logic [WORD-1:0] inst_i,
    input  logic [ADDR-1:0] pc_i,
    output logic            out_v_o,
    input  logic            stall_i,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    input  logic            flush_i,
    output logic [PTRW:0]   count_o
);

    localparam int CW = PTRW + 1;
    localparam logic [PTRW:0] FULL_CNT = CW'(DEPTH);

    logic [PTRW-1:0]      rd_ptr;
    logic [PTRW-1:0]      wr_ptr;
    logic [PTRW:0]        count;
    logic                 push;
    logic                 pop;
    q_op_e                op;
    logic [WORD+ADDR-1:0] rd_data;

    // Ready depends only on the registered count, so stall never reaches fetch combinationally.
    assign in_rdy_o = (count != FULL_CNT);
    assign out_v_o  = (count != '0);
    assign push     = in_v_i & in_rdy_o & ~flush_i;
    assign pop      = out_v_o & ~stall_i & ~flush_i;
    assign op       = q_op_e'({push, pop});
    assign count_o  = count;

    assign inst_o = out_v_o ? rd_data[WORD+ADDR-1:ADDR] : '0;
    assign pc_o   = out_v_o ? rd_data[ADDR-1:0]         : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WORD + ADDR),
        .PTRW  (PTRW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({inst_i, pc_i}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_queue;

    localparam int WORD  = 32;
    localparam int ADDR  = 32;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic            clk;
    logic            reset;
    logic            in_v_i;
    logic            in_rdy_o;
    logic [WORD-1:0] inst_i;
    logic [ADDR-1:0] pc_i;
    logic            out_v_o;
    logic            stall_i;
    logic [WORD-1:0] inst_o;
    logic [ADDR-1:0] pc_o;
    logic            flush_i;
    logic [PTRW:0]   count_o;

    int vec_count  = 0;
    int miss_count = 0;

    logic [WORD+ADDR-1:0] model_q [$];

    fetch_queue #(
        .WORD  (WORD),
        .ADDR  (ADDR),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_v_i   (in_v_i),
        .in_rdy_o (in_rdy_o),
        .inst_i   (inst_i),
        .pc_i     (pc_i),
        .out_v_o  (out_v_o),
        .stall_i  (stall_i),
        .inst_o   (inst_o),
        .pc_o     (pc_o),
        .flush_i  (flush_i),
        .count_o  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain FIFO of {inst, pc}, updated from the interface rules.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_q.delete();
        end else begin
            automatic int  sz     = model_q.size();
            automatic logic do_pop  = (sz != 0) && !stall_i && !flush_i;
            automatic logic do_push = in_v_i && (sz != DEPTH) && !flush_i;
            if (flush_i) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back({inst_i, pc_i});
            end
        end
    end

    // Every falling edge the DUT must agree with the model.
    always @(negedge clk) begin
        automatic int sz = model_q.size();
        automatic logic [WORD+ADDR-1:0] head = (sz != 0) ? model_q[0] : '0;
        check_output("cyc_out_v",  64'(out_v_o),  64'(sz != 0));
        check_output("cyc_in_rdy", 64'(in_rdy_o), 64'(sz != DEPTH));
        check_output("cyc_count",  64'(count_o),  64'(sz));
        check_output("cyc_inst",   64'(inst_o),   64'(head[WORD+ADDR-1:ADDR]));
        check_output("cyc_pc",     64'(pc_o),     64'(head[ADDR-1:0]));
    end

    // Drive one cycle of inputs, then return 1 time unit after the edge that consumed them.
    task automatic apply_stimulus(input logic v, input logic [WORD-1:0] inst, input logic [ADDR-1:0] pc,
                                  input logic stall, input logic flush);
        in_v_i  = v;
        inst_i  = inst;
        pc_i    = pc;
        stall_i = stall;
        flush_i = flush;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        in_v_i  = 1'b0;
        inst_i  = '0;
        pc_i    = '0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check_output("rst_count",  64'(count_o),  64'd0);
        check_output("rst_in_rdy", 64'(in_rdy_o), 64'd1);
        check_output("rst_out_v",  64'(out_v_o),  64'd0);
        check_output("rst_inst",   64'(inst_o),   64'd0);
        check_output("rst_pc",     64'(pc_o),     64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single push then immediate consumption.
        apply_stimulus(1'b1, 32'h13, 32'h0, 1'b0, 1'b0);
        check_output("p1_out_v", 64'(out_v_o), 64'd1);
        check_output("p1_inst",  64'(inst_o),  64'h13);
        check_output("p1_pc",    64'(pc_o),    64'h0);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("p1_count_after", 64'(count_o), 64'd0);

        // Fill under stall; fifth pair is held off.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'h1000 + 32'(4 * i), 32'(4 * i), 1'b1, 1'b0);
        end
        check_output("full_count",  64'(count_o),  64'd4);
        check_output("full_in_rdy", 64'(in_rdy_o), 64'd0);
        check_output("full_head",   64'(pc_o),     64'h0);
        apply_stimulus(1'b1, 32'h1010, 32'h10, 1'b1, 1'b0);
        check_output("held_count", 64'(count_o), 64'd4);

        // Release stall while the held pair is still offered: pop frees a slot one cycle later.
        apply_stimulus(1'b1, 32'h1010, 32'h10, 1'b0, 1'b0);
        check_output("popfull_count", 64'(count_o), 64'd3);
        check_output("drain_pc4",     64'(pc_o),    64'h4);
        apply_stimulus(1'b1, 32'h1010, 32'h10, 1'b0, 1'b0);
        check_output("held_accept_count", 64'(count_o), 64'd3);
        check_output("drain_pc8",         64'(pc_o),    64'h8);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("drain_pcC",   64'(pc_o),   64'hC);
        check_output("drain_instC", 64'(inst_o), 64'h100C);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("drain_pc10", 64'(pc_o), 64'h10);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("drain_empty", 64'(out_v_o), 64'd0);

        // Flush with three entries and a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'h2000 + 32'(4 * i), 32'h20 + 32'(4 * i), 1'b1, 1'b0);
        end
        check_output("preflush_count", 64'(count_o), 64'd3);
        apply_stimulus(1'b1, 32'h202C, 32'h2C, 1'b1, 1'b1);
        check_output("flush_count", 64'(count_o), 64'd0);
        check_output("flush_out_v", 64'(out_v_o), 64'd0);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("flush_nodrop", 64'(out_v_o), 64'd0);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
        check_output("flush_empty_count", 64'(count_o), 64'd0);

        // Streaming push/pop across ten entries wraps the pointers.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 32'h3000 + 32'(i), 32'h40 + 32'(4 * i), 1'b0, 1'b0);
            check_output("stream_count", 64'(count_o), 64'd1);
            check_output("stream_pc",    64'(pc_o),    64'(32'h40 + 32'(4 * i)));
        end
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("stream_drained", 64'(count_o), 64'd0);

        // Asynchronous reset between edges with two entries queued.
        apply_stimulus(1'b1, 32'h4000, 32'h80, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h4004, 32'h84, 1'b1, 1'b0);
        in_v_i = 1'b0;
        check_output("prereset_count", 64'(count_o), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_rst_out_v",  64'(out_v_o),  64'd0);
        check_output("async_rst_count",  64'(count_o),  64'd0);
        check_output("async_rst_in_rdy", 64'(in_rdy_o), 64'd1);
        check_output("async_rst_pc",     64'(pc_o),     64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(1'b1, 32'h5000, 32'h90, 1'b0, 1'b0);
        check_output("post_rst_pc", 64'(pc_o), 64'h90);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WORD, default 32: instruction width in bits.
REQ-002 Parameter ADDR, default 32: PC width in bits.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 Parameter PTRW, default log2(DEPTH): read/write pointer width.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_v_i  in  1  fetch side offers a valid instruction/PC pair.
REQ-008 in_rdy_o  out  1  queue accepts a pair this cycle.
REQ-009 inst_i  in  WORD  fetched instruction.
REQ-010 pc_i  in  ADDR  PC of inst_i.
REQ-011 out_v_o  out  1  head entry valid toward decode.
REQ-012 stall_i  in  1  decode stalled; head is not consumed.
REQ-013 inst_o  out  WORD  head instruction.
REQ-014 pc_o  out  ADDR  head PC.
REQ-015 flush_i  in  1  branch taken; discard all queued and incoming entries.
REQ-016 count_o  out  PTRW+1  number of valid entries.

Function
REQ-017 Push = in_v_i & in_rdy_o & ~flush_i; pop = out_v_o & ~stall_i & ~flush_i.
REQ-018 in_rdy_o = (count_o != DEPTH); it is combinational from registered state only, with no path from stall_i.
REQ-019 out_v_o = (count_o != 0); inst_o and pc_o are driven to 0 whenever out_v_o = 0.
REQ-020 Push writes {inst_i, pc_i} at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-021 Pop advances rd_ptr modulo DEPTH; inst_o and pc_o always show the entry at rd_ptr.
REQ-022 count_o: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-023 Latency: a pair pushed in cycle N appears on out_v_o/inst_o/pc_o in cycle N+1 at the earliest; there is no same-cycle bypass.
REQ-024 Empty queue with a push: out_v_o = 1 next cycle; a pop is impossible in the same cycle.
REQ-025 Full queue: in_rdy_o = 0, so a pop in that cycle frees a slot only from the next cycle onward.
REQ-026 Pushes are accepted while stall_i = 1 until the queue is full.
REQ-027 Flush: on the next edge count_o = 0 and rd_ptr = wr_ptr = 0; any same-cycle push is dropped; out_v_o = 0 in the following cycle.
REQ-028 Flush while empty has no effect beyond REQ-027.
REQ-029 Flush has priority over push, pop and stall.
REQ-030 Entry order is strict FIFO; no entry is duplicated or lost except by flush.

Reset
REQ-031 While reset = 0: count_o = 0, pointers = 0, out_v_o = 0, in_rdy_o = 1, inst_o = 0, pc_o = 0.
REQ-032 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
REQ-033 Storage array contents are not reset; the output gating of REQ-019 hides them.

Structure
REQ-034 WORD and ADDR come from the shared parameter include; DEPTH and PTRW are local parameters overridable per instance.
REQ-035 Storage is a sub-module fetch_queue_mem: DEPTH x (WORD+ADDR), one synchronous write port, one asynchronous read port.
REQ-036 Pointer, count and flush control live in fetch_queue itself.

Verification
REQ-037 Reset, then push 0x00000013@pc 0x0 with stall_i = 0 -> next cycle out_v_o = 1, inst_o = 0x13, pc_o = 0; one cycle later count_o = 0.
REQ-038 stall_i = 1, push 5 pairs (pc 0,4,8,C,10) with DEPTH = 4 -> in_rdy_o = 0 after the 4th push, count_o = 4; the 5th is held by the source; release stall -> pcs 0,4,8,C drain in order.
REQ-039 Full queue with push attempt and pop in the same cycle -> count_o = 3 next cycle; the held pair is accepted the cycle after.
REQ-040 count_o = 3, flush_i = 1 together with in_v_i = 1 -> next cycle count_o = 0, out_v_o = 0, the pushed pair never appears.
REQ-041 Continuous push/pop across 10 entries -> pointers wrap, order preserved, count_o stays at 1.
REQ-042 reset pulsed low between edges with count_o = 2 -> out_v_o = 0 and count_o = 0 immediately, before the next edge.
